// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the 64-bit ALU.
// Resolves RAW hazards by forwarding from EX, MEM and WB. Picks rs2 or the
// immediate as the second operand. Registers operands and function codes in a
// single holding register behind a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until it is taken.
// in_ready is combinational. It drops on a flush, on a pending-EX hazard, or
// when the holding register is full and not being drained.
module alu_operand_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  ex_fwd_we,
  input  logic [REG_ADDR_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]       ex_fwd_data,
  input  logic                  ex_fwd_pending,
  input  logic                  mem_fwd_we,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_we,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_in1,
  output logic [XLEN-1:0]       out_in2,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write
);

  logic            stall;
  logic            accept;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic [XLEN-1:0] rs1_resolved;
  logic [XLEN-1:0] rs2_resolved;
  logic [XLEN-1:0] in2_sel;

  // Forwarding priority: x0 is zero, then the youngest ready result wins.
  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_data,
    input logic                  ex_pending,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]       mem_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_data
  );
    logic [XLEN-1:0] val;
    if (addr == '0)                                   val = '0;
    else if (ex_we && (ex_rd == addr) && !ex_pending) val = ex_data;
    else if (mem_we && (mem_rd == addr))              val = mem_data;
    else if (wb_we && (wb_rd == addr))                val = wb_data;
    else                                              val = rf_data;
    return val;
  endfunction

  // Hazard detection: a used source waits on an EX result not yet produced.
  always_comb begin
    rs1_hazard = (in_rs1_addr != '0) && ex_fwd_we &&
                 (ex_fwd_rd == in_rs1_addr) && ex_fwd_pending;
    rs2_hazard = !in_use_imm && (in_rs2_addr != '0) && ex_fwd_we &&
                 (ex_fwd_rd == in_rs2_addr) && ex_fwd_pending;
    stall      = in_valid && (rs1_hazard || rs2_hazard);
    in_ready   = !flush && (!out_valid || out_ready) && !stall;
    accept     = in_valid && in_ready;
  end

  // Operand resolution and second-operand selection.
  always_comb begin
    rs1_resolved = resolve(in_rs1_addr, in_rs1_data,
                           ex_fwd_we, ex_fwd_rd, ex_fwd_data, ex_fwd_pending,
                           mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    rs2_resolved = resolve(in_rs2_addr, in_rs2_data,
                           ex_fwd_we, ex_fwd_rd, ex_fwd_data, ex_fwd_pending,
                           mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    in2_sel      = in_use_imm ? in_imm : rs2_resolved;
  end

  // Holding register: flush kills, accept loads, drain without accept empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_in1       <= '0;
      out_in2       <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_rd_addr   <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_in1       <= rs1_resolved;
      out_in2       <= in2_sel;
      out_funct3    <= in_funct3;
      out_funct7    <= in_funct7;
      out_rd_addr   <= in_rd_addr;
      out_reg_write <= in_reg_write;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding priority, x0, hazard stall,
// immediate select, throughput, backpressure hold, flush and reset.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [63:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_reg_write;
  logic        ex_fwd_we, ex_fwd_pending, mem_fwd_we, wb_fwd_we;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_fwd_rd;
  logic [63:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_in1, out_in2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  alu_operand_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .ex_fwd_pending(ex_fwd_pending),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    in_funct3 = 0; in_funct7 = 0; in_rd_addr = 0; in_reg_write = 0;
    ex_fwd_we = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_pending = 0;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    out_ready = 1;
  endtask

  task automatic drive_op(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic use_imm,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic rw);
    in_valid = 1; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm;
    in_funct3 = f3; in_funct7 = f7; in_rd_addr = rd; in_reg_write = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_in1 !== 64'h0 || out_in2 !== 64'h0) begin bad++; $display("FAIL reset_data in1=%h in2=%h exp=0", out_in1, out_in2); end
    total++; if (out_reg_write !== 1'b0 || out_rd_addr !== 5'd0 || out_funct3 !== 3'd0 || out_funct7 !== 7'd0) begin bad++; $display("FAIL reset_ctrl rw=%0b rd=%0d f3=%0d f7=%0d exp=0", out_reg_write, out_rd_addr, out_funct3, out_funct7); end
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    drive_op(5'd3, 5'd4, 64'h10, 64'h20, 64'h0, 1'b0, 3'b000, 7'h00, 5'd7, 1'b1);
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (out_in1 !== 64'h10 || out_in2 !== 64'h20) begin bad++; $display("FAIL basic_ops in1=%h in2=%h exp=10/20", out_in1, out_in2); end
    total++; if (out_rd_addr !== 5'd7 || out_reg_write !== 1'b1) begin bad++; $display("FAIL basic_rd rd=%0d rw=%0b exp=7/1", out_rd_addr, out_reg_write); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_forward();
    drive_op(5'd3, 5'd4, 64'h10, 64'h20, 64'h0, 1'b0, 3'b000, 7'h00, 5'd7, 1'b1);
    mem_fwd_we = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'hAA;
    wb_fwd_we = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'hBB;
    step();
    total++; if (out_in1 !== 64'hAA || out_in2 !== 64'h20) begin bad++; $display("FAIL fwd_mem in1=%h in2=%h exp=aa/20", out_in1, out_in2); end
    ex_fwd_we = 1; ex_fwd_rd = 5'd3; ex_fwd_data = 64'hCC; ex_fwd_pending = 0;
    step();
    total++; if (out_in1 !== 64'hCC) begin bad++; $display("FAIL fwd_ex in1=%h exp=cc", out_in1); end
    ex_fwd_we = 0; mem_fwd_we = 0;
    step();
    total++; if (out_in1 !== 64'hBB) begin bad++; $display("FAIL fwd_wb in1=%h exp=bb", out_in1); end
    wb_fwd_rd = 5'd4;
    step();
    total++; if (out_in1 !== 64'h10 || out_in2 !== 64'hBB) begin bad++; $display("FAIL fwd_rs2_wb in1=%h in2=%h exp=10/bb", out_in1, out_in2); end
    idle_inputs();
    step();
  endtask

  task automatic test_x0();
    drive_op(5'd0, 5'd0, 64'h55, 64'h66, 64'h0, 1'b0, 3'b001, 7'h00, 5'd1, 1'b1);
    ex_fwd_we = 1; ex_fwd_rd = 0; ex_fwd_data = 64'hFF;
    mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 64'hFF;
    wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 64'hFF;
    step();
    total++; if (out_valid !== 1'b1 || out_in1 !== 64'h0 || out_in2 !== 64'h0) begin bad++; $display("FAIL x0 v=%0b in1=%h in2=%h exp=1/0/0", out_valid, out_in1, out_in2); end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    ex_fwd_we = 1; ex_fwd_rd = 5'd5; ex_fwd_data = 64'hDD; ex_fwd_pending = 1;
    drive_op(5'd1, 5'd5, 64'h11, 64'h55, 64'h0, 1'b0, 3'b000, 7'h00, 5'd2, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b exp=0", in_ready); end
    step(); step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold v=%0b rdy=%0b exp=0/0", out_valid, in_ready); end
    ex_fwd_pending = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_in2 !== 64'hDD || out_in1 !== 64'h11) begin bad++; $display("FAIL stall_fwd v=%0b in1=%h in2=%h exp=1/11/dd", out_valid, out_in1, out_in2); end
    ex_fwd_pending = 1;
    drive_op(5'd1, 5'd5, 64'h11, 64'h55, 64'h7FF, 1'b1, 3'b000, 7'h00, 5'd2, 1'b1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL imm_no_stall got=%0b exp=1", in_ready); end
    step();
    total++; if (out_in2 !== 64'h7FF) begin bad++; $display("FAIL imm_in2 got=%h exp=7ff", out_in2); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int vcnt;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive_op(5'd6, 5'd0, 64'h100 + 64'(i), 64'h0, 64'h0, 1'b0, 3'(i + 1), 7'h20, 5'd9, 1'b1);
      exp_q.push_back(64'h100 + 64'(i));
      step();
      if (out_valid === 1'b1) vcnt++;
      total++; if (out_in1 !== exp_q[0] || out_funct3 !== 3'(i + 1) || out_funct7 !== 7'h20) begin bad++; $display("FAIL b2b_data%0d in1=%h f3=%0d f7=%h exp=%h/%0d/20", i, out_in1, out_funct3, out_funct7, exp_q[0], i + 1); end
      void'(exp_q.pop_front());
    end
    total++; if (vcnt != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", vcnt); end
    out_ready = 0;
    drive_op(5'd6, 5'd0, 64'h200, 64'h0, 64'h0, 1'b0, 3'd7, 7'h00, 5'd10, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%0b exp=0", c, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_in1 !== 64'h103 || out_funct3 !== 3'd4) begin bad++; $display("FAIL hold_stable%0d v=%0b in1=%h f3=%0d exp=1/103/4", c, out_valid, out_in1, out_funct3); end
    end
    out_ready = 1;
    step();
    total++; if (out_in1 !== 64'h200 || out_rd_addr !== 5'd10) begin bad++; $display("FAIL hold_resume in1=%h rd=%0d exp=200/10", out_in1, out_rd_addr); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    flush = 1;
    drive_op(5'd6, 5'd0, 64'h300, 64'h0, 64'h0, 1'b0, 3'd1, 7'h00, 5'd11, 1'b1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("FAIL flush_kill v=%0b rw=%0b exp=0/0", out_valid, out_reg_write); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    drive_op(5'd6, 5'd0, 64'h400, 64'h0, 64'h0, 1'b0, 3'd2, 7'h00, 5'd12, 1'b1);
    step();
    in_valid = 0; out_ready = 0;
    total++; if (out_valid !== 1'b1 || out_in1 !== 64'h400) begin bad++; $display("FAIL rmid_load v=%0b in1=%h exp=1/400", out_valid, out_in1); end
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_in1 !== 64'h0 || out_reg_write !== 1'b0) begin bad++; $display("FAIL rmid_clear v=%0b in1=%h rw=%0b exp=0", out_valid, out_in1, out_reg_write); end
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", in_ready); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_x0();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Accepts decoded instructions from decode and resolves RAW hazards by forwarding from EX, MEM and WB.
- Selects the second operand as either rs2 or the immediate.
- Registers the ALU operands (in1, in2) and function codes (funct3, funct7) behind a valid/ready handshake.

Parameters:
XLEN, 64, datapath width; must match the ALU operand width.
REG_ADDR_W, 5, register address width (32 architectural registers, x0 hardwired to zero).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of the held instruction (branch mispredict / trap).
in_valid  input  1  decode presents an instruction.
in_ready  output  1  stage accepts this cycle.
in_rs1_addr  input  REG_ADDR_W  source 1 register.
in_rs2_addr  input  REG_ADDR_W  source 2 register.
in_rs1_data  input  XLEN  register-file read data for rs1.
in_rs2_data  input  XLEN  register-file read data for rs2.
in_imm  input  XLEN  sign-extended immediate.
in_use_imm  input  1  1 = in2 takes imm, 0 = rs2.
in_funct3  input  3  passed to the ALU.
in_funct7  input  7  passed to the ALU.
in_rd_addr  input  REG_ADDR_W  destination register.
in_reg_write  input  1  instruction writes rd.
ex_fwd_we  input  1  EX-stage instruction writes its rd.
ex_fwd_rd  input  REG_ADDR_W  EX-stage rd.
ex_fwd_data  input  XLEN  EX-stage result.
ex_fwd_pending  input  1  EX result not yet available (load or multi-cycle op).
mem_fwd_we  input  1  MEM-stage write enable.
mem_fwd_rd  input  REG_ADDR_W  MEM-stage rd.
mem_fwd_data  input  XLEN  MEM-stage result.
wb_fwd_we  input  1  WB-stage write enable.
wb_fwd_rd  input  REG_ADDR_W  WB-stage rd.
wb_fwd_data  input  XLEN  WB-stage result.
out_valid  output  1  registered operands valid toward the ALU.
out_ready  input  1  EX consumes this cycle.
out_in1  output  XLEN  ALU in1.
out_in2  output  XLEN  ALU in2.
out_funct3  output  3  ALU funct3.
out_funct7  output  7  ALU funct7.
out_rd_addr  output  REG_ADDR_W  destination register.
out_reg_write  output  1  write enable.

Behaviour:
- Reset (rst_n low, asynchronous): all out_* registers clear to 0, including out_valid.
- Single holding register; latency is one cycle from accept to out_valid.
- stall = in_valid and a hazard exists: for some used source rsN (rs2 counts as used only when in_use_imm=0), rsN != 0, ex_fwd_we=1, ex_fwd_rd == rsN, and ex_fwd_pending=1.
- in_ready = (!out_valid || out_ready) and !stall. in_ready is combinational.
- Accept = in_valid && in_ready. On accept, out_* load the resolved values and out_valid is set to 1.
- If out_ready=1 and there is no accept, out_valid clears to 0.
- Hold: when out_valid=1 and out_ready=0, all out_* remain stable.
- Forward resolution, applied per source:
  - If the address is 0, the value is 0.
  - Otherwise, priority is EX (we && rd match && !pending), then MEM, then WB, then register-file data.
- out_in1 = resolved rs1.
- out_in2 = in_use_imm ? in_imm : resolved rs2.
- funct3, funct7, rd and reg_write pass through unchanged.
- Flush is synchronous and highest priority:
  - next out_valid = 0, and out_reg_write = 0.
  - in_ready is forced to 0 that cycle, so no accept occurs.
  - Data registers may hold stale values.
- Simultaneous drain and accept (out_valid=1, out_ready=1, accept): the new instruction loads and out_valid stays 1. This sustains full throughput of one op per cycle.
- Assertion in reset mid-operation: the held instruction is discarded immediately. After release, in_ready follows the rules above.

Test Plan:
- Reset, then rs1=3 (rf 0x10), rs2=4 (rf 0x20), funct3=000, funct7=0, no forwarding, out_ready=1 -> next cycle out_valid=1, in1=0x10, in2=0x20.
- Same op with mem_fwd_we=1, mem_fwd_rd=3, mem_fwd_data=0xAA, and wb_fwd_rd=3, wb_fwd_data=0xBB -> in1=0xAA (MEM beats WB). Adding ex_fwd rd=3, data=0xCC, pending=0 -> in1=0xCC.
- rs1=0 with all forward sources targeting rd=0 with data 0xFF -> in1=0.
- ex_fwd_we=1, rd=5, pending=1, and in rs2=5 with use_imm=0 -> in_ready=0 until pending drops, then in2=ex data. With use_imm=1 and imm=0x7FF -> no stall, in2=0x7FF.
- Back-to-back stream of 4 ops with out_ready=1 -> 4 consecutive out_valid cycles. Drop out_ready for 2 cycles -> outputs frozen and in_ready=0.
- flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, out_reg_write=0, and the incoming op is not accepted.
